// File: rtl/attr_lookup_requester_if.sv
// Result-in / request-out bus of the attribute lookup requester.
// master = analyzer and downstream lookup side, slave = requester.
interface attr_lookup_requester_if #(
   parameter int ATTRIBUTE_DATA_WIDTH = 135,
   parameter int TUPLE_WIDTH          = 104,
   parameter int BYTES_COUNT_WIDTH    = 16,
   parameter int PKT_FLAGS_WIDTH      = 5,
   parameter int PRTCL_ID_WIDTH       = 2,
   parameter int NUM_INPUT_QUEUES     = 8
);
   logic                            pkt_valid;
   logic [ATTRIBUTE_DATA_WIDTH-1:0] pkt_attributes;
   logic                            req_valid;
   logic                            req_ready;
   logic [TUPLE_WIDTH-1:0]          req_tuple;
   logic [BYTES_COUNT_WIDTH-1:0]    req_bytes;
   logic [PKT_FLAGS_WIDTH-1:0]      req_flags;
   logic [PRTCL_ID_WIDTH-1:0]       req_prtcl_id;
   logic [NUM_INPUT_QUEUES-1:0]     req_input_if;

   modport master (
      output pkt_valid, pkt_attributes, req_ready,
      input  req_valid, req_tuple, req_bytes, req_flags, req_prtcl_id, req_input_if
   );
   modport slave (
      input  pkt_valid, pkt_attributes, req_ready,
      output req_valid, req_tuple, req_bytes, req_flags, req_prtcl_id, req_input_if
   );
endinterface

// File: rtl/attr_lookup_requester.sv
// Filters analyzer results by protocol ID, buffers them in a small FIFO and
// presents them as lookup requests over valid/ready, with saturating stats.
module attr_lookup_requester #(
   parameter int ATTRIBUTE_DATA_WIDTH = 135,
   parameter int TUPLE_WIDTH          = 104,
   parameter int BYTES_COUNT_WIDTH    = 16,
   parameter int PKT_FLAGS_WIDTH      = 5,
   parameter int PRTCL_ID_WIDTH       = 2,
   parameter int NUM_INPUT_QUEUES     = 8,
   parameter int FIFO_DEPTH           = 4,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                              clk,
   input  logic                              resetn,
   attr_lookup_requester_if.slave            bus,
   input  logic [(1<<PRTCL_ID_WIDTH)-1:0]    cfg_prtcl_en,
   input  logic                              cfg_clr_cnt,
   output logic [CNT_WIDTH-1:0]              accept_cnt,
   output logic [CNT_WIDTH-1:0]              filter_cnt,
   output logic [CNT_WIDTH-1:0]              drop_cnt
);
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int OCC_W     = PTR_W + 1;
   localparam int BYTES_LSB = TUPLE_WIDTH;
   localparam int FLAGS_LSB = BYTES_LSB + BYTES_COUNT_WIDTH;
   localparam int PID_LSB   = FLAGS_LSB + PKT_FLAGS_WIDTH;
   localparam int IF_LSB    = PID_LSB + PRTCL_ID_WIDTH;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

   logic [ATTRIBUTE_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]                occ_q, occ_d;
   logic [CNT_WIDTH-1:0]            accept_cnt_q, accept_cnt_d;
   logic [CNT_WIDTH-1:0]            filter_cnt_q, filter_cnt_d;
   logic [CNT_WIDTH-1:0]            drop_cnt_q, drop_cnt_d;
   logic [ATTRIBUTE_DATA_WIDTH-1:0] head;
   logic [PRTCL_ID_WIDTH-1:0]       pkt_pid;
   logic                            pkt_en, pop, push, filt, drop;

   assign pkt_pid = bus.pkt_attributes[PID_LSB +: PRTCL_ID_WIDTH];
   assign pkt_en  = cfg_prtcl_en[pkt_pid];
   assign pop     = bus.req_valid && bus.req_ready;
   // A same-cycle pop frees a slot in a full FIFO, so the push still lands.
   assign push    = bus.pkt_valid && pkt_en && ((occ_q < FULL_OCC) || pop);
   assign filt    = bus.pkt_valid && !pkt_en;
   assign drop    = bus.pkt_valid && pkt_en && !push;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      accept_cnt_d = accept_cnt_q;
      filter_cnt_d = filter_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      if (push && accept_cnt_q != '1) accept_cnt_d = accept_cnt_q + 1'b1;
      if (filt && filter_cnt_q != '1) filter_cnt_d = filter_cnt_q + 1'b1;
      if (drop && drop_cnt_q   != '1) drop_cnt_d   = drop_cnt_q + 1'b1;
      if (cfg_clr_cnt) begin
         accept_cnt_d = '0;
         filter_cnt_d = '0;
         drop_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         accept_cnt_q <= '0;
         filter_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         accept_cnt_q <= accept_cnt_d;
         filter_cnt_q <= filter_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // Payload storage carries no reset; only occupancy qualifies it.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.pkt_attributes;
   end

   assign head             = mem_q[rd_ptr_q];
   assign bus.req_valid    = (occ_q != '0);
   assign bus.req_tuple    = head[TUPLE_WIDTH-1:0];
   assign bus.req_bytes    = head[BYTES_LSB +: BYTES_COUNT_WIDTH];
   assign bus.req_flags    = head[FLAGS_LSB +: PKT_FLAGS_WIDTH];
   assign bus.req_prtcl_id = head[PID_LSB +: PRTCL_ID_WIDTH];
   assign bus.req_input_if = head[IF_LSB +: NUM_INPUT_QUEUES];

   assign accept_cnt = accept_cnt_q;
   assign filter_cnt = filter_cnt_q;
   assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_attr_lookup_requester.sv
// Randomized and directed bench for attr_lookup_requester against a queue model.
module tb_attr_lookup_requester;
   localparam int AW = 135, TW = 104, BW = 16, FW = 5, PW = 2, NQ = 8;
   localparam int DEPTH = 4, CW = 8;
   localparam int B_LSB = 104, F_LSB = 120, P_LSB = 125, I_LSB = 127;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [3:0]    cfg_prtcl_en = 4'b1111;
   logic          cfg_clr_cnt = 1'b0;
   logic [CW-1:0] accept_cnt, filter_cnt, drop_cnt;

   attr_lookup_requester_if #(.ATTRIBUTE_DATA_WIDTH(AW), .TUPLE_WIDTH(TW),
      .BYTES_COUNT_WIDTH(BW), .PKT_FLAGS_WIDTH(FW), .PRTCL_ID_WIDTH(PW),
      .NUM_INPUT_QUEUES(NQ)) bus ();

   attr_lookup_requester #(.ATTRIBUTE_DATA_WIDTH(AW), .TUPLE_WIDTH(TW),
      .BYTES_COUNT_WIDTH(BW), .PKT_FLAGS_WIDTH(FW), .PRTCL_ID_WIDTH(PW),
      .NUM_INPUT_QUEUES(NQ), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .cfg_prtcl_en(cfg_prtcl_en),
      .cfg_clr_cnt(cfg_clr_cnt), .accept_cnt(accept_cnt),
      .filter_cnt(filter_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue plus saturating counters.
   logic [AW-1:0] mq[$];
   logic [CW-1:0] m_acc, m_filt, m_drop;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mq.delete();
         m_acc = '0; m_filt = '0; m_drop = '0;
      end else begin
         if (mq.size() != 0 && bus.req_ready) void'(mq.pop_front());
         if (bus.pkt_valid) begin
            if (!cfg_prtcl_en[bus.pkt_attributes[P_LSB +: PW]]) begin
               if (m_filt != '1) m_filt = m_filt + 1'b1;
            end else if (mq.size() < DEPTH) begin
               mq.push_back(bus.pkt_attributes);
               if (m_acc != '1) m_acc = m_acc + 1'b1;
            end else begin
               if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
         end
         if (cfg_clr_cnt) begin
            m_acc = '0; m_filt = '0; m_drop = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("req_valid", AW'(bus.req_valid), AW'(mq.size() != 0));
         if (mq.size() != 0 && bus.req_valid) begin
            chk("req_tuple",    AW'(bus.req_tuple),    AW'(mq[0][TW-1:0]));
            chk("req_bytes",    AW'(bus.req_bytes),    AW'(mq[0][B_LSB +: BW]));
            chk("req_flags",    AW'(bus.req_flags),    AW'(mq[0][F_LSB +: FW]));
            chk("req_prtcl_id", AW'(bus.req_prtcl_id), AW'(mq[0][P_LSB +: PW]));
            chk("req_input_if", AW'(bus.req_input_if), AW'(mq[0][I_LSB +: NQ]));
         end
         chk("accept_cnt", AW'(accept_cnt), AW'(m_acc));
         chk("filter_cnt", AW'(filter_cnt), AW'(m_filt));
         chk("drop_cnt",   AW'(drop_cnt),   AW'(m_drop));
      end
   end

   function automatic logic [AW-1:0] mk(input logic [7:0] proto, input logic [31:0] ipsrc,
                                        input logic [15:0] pdst, input logic [15:0] bytes,
                                        input logic [1:0] pid, input logic [7:0] inif);
      return {inif, pid, 5'h0a, bytes, pdst, 16'h1234, 32'hC0A80001, ipsrc, proto};
   endfunction

   // Inputs change 2 time units after each rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse(input logic [AW-1:0] a);
      bus.pkt_valid = 1'b1;
      bus.pkt_attributes = a;
      tick();
      bus.pkt_valid = 1'b0;
   endtask

   task automatic clr();
      cfg_clr_cnt = 1'b1;
      tick();
      cfg_clr_cnt = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] a;
      bus.pkt_valid = 1'b0;
      bus.pkt_attributes = '0;
      bus.req_ready = 1'b1;
      tick(2);
      chk("reset_valid", AW'(bus.req_valid), '0);
      chk("reset_accept", AW'(accept_cnt), '0);
      resetn = 1'b1;
      cmp_en = 1'b1;
      tick();

      // 1: single result passes straight through
      pulse(mk(8'h06, 32'h0A000001, 16'h0050, 16'd64, 2'd1, 8'h04));
      chk("t1_valid", AW'(bus.req_valid), AW'(1));
      chk("t1_proto", AW'(bus.req_tuple[7:0]), AW'(8'h06));
      chk("t1_ipsrc", AW'(bus.req_tuple[39:8]), AW'(32'h0A000001));
      chk("t1_pdst", AW'(bus.req_tuple[103:88]), AW'(16'h0050));
      chk("t1_bytes", AW'(bus.req_bytes), AW'(64));
      chk("t1_inif", AW'(bus.req_input_if), AW'(8'h04));
      chk("t1_pid", AW'(bus.req_prtcl_id), AW'(1));
      tick();
      chk("t1_empty", AW'(bus.req_valid), '0);
      chk("t1_acc", AW'(accept_cnt), AW'(1));

      // 2: protocol filter
      clr();
      cfg_prtcl_en = 4'b0111;
      pulse(mk(8'h11, 32'h1, 16'h2, 16'd33, 2'd3, 8'h01));
      chk("t2_filtered", AW'(bus.req_valid), '0);
      pulse(mk(8'h11, 32'h1, 16'h2, 16'd77, 2'd0, 8'h02));
      chk("t2_bytes", AW'(bus.req_bytes), AW'(77));
      chk("t2_filt", AW'(filter_cnt), AW'(1));
      chk("t2_acc", AW'(accept_cnt), AW'(1));
      cfg_prtcl_en = 4'b1111;
      tick();

      // 3: overflow under backpressure
      clr();
      bus.req_ready = 1'b0;
      for (int i = 1; i <= 6; i++) pulse(mk(8'h06, 32'h5, 16'h6, 16'(i), 2'd2, 8'h80));
      chk("t3_drop", AW'(drop_cnt), AW'(2));
      chk("t3_acc", AW'(accept_cnt), AW'(4));
      bus.req_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("t3_order", AW'(bus.req_bytes), AW'(i));
         tick();
      end
      chk("t3_empty", AW'(bus.req_valid), '0);

      // 4: push and pop together while full
      clr();
      bus.req_ready = 1'b0;
      for (int i = 11; i <= 14; i++) pulse(mk(8'h06, 32'h5, 16'h6, 16'(i), 2'd0, 8'h01));
      bus.req_ready = 1'b1;
      pulse(mk(8'h06, 32'h5, 16'h6, 16'd15, 2'd0, 8'h01));
      bus.req_ready = 1'b0;
      chk("t4_drop", AW'(drop_cnt), AW'(0));
      chk("t4_acc", AW'(accept_cnt), AW'(5));
      chk("t4_head", AW'(bus.req_bytes), AW'(12));
      pulse(mk(8'h06, 32'h5, 16'h6, 16'd16, 2'd0, 8'h01));
      chk("t4_still_full", AW'(drop_cnt), AW'(1));
      bus.req_ready = 1'b1;
      for (int i = 12; i <= 15; i++) begin
         chk("t4_order", AW'(bus.req_bytes), AW'(i));
         tick();
      end
      chk("t4_empty", AW'(bus.req_valid), '0);

      // 5: outputs hold while stalled
      bus.req_ready = 1'b0;
      a = mk(8'h2F, 32'hDEADBEEF, 16'h0BB8, 16'd21, 2'd3, 8'h40);
      pulse(a);
      for (int i = 0; i < 2; i++) begin
         chk("t5_tuple", AW'(bus.req_tuple), AW'(a[TW-1:0]));
         chk("t5_bytes", AW'(bus.req_bytes), AW'(21));
         chk("t5_valid", AW'(bus.req_valid), AW'(1));
         tick();
      end
      bus.req_ready = 1'b1;
      tick();
      chk("t5_one_xfer", AW'(bus.req_valid), '0);

      // 6: reset mid-operation, then saturation and clear
      bus.req_ready = 1'b0;
      for (int i = 0; i < 3; i++) pulse(mk(8'h01, 32'h7, 16'h8, 16'(40 + i), 2'd1, 8'h08));
      resetn = 1'b0;
      #1;
      chk("t6_rst_valid", AW'(bus.req_valid), '0);
      chk("t6_rst_acc", AW'(accept_cnt), '0);
      chk("t6_rst_filt", AW'(filter_cnt), '0);
      chk("t6_rst_drop", AW'(drop_cnt), '0);
      tick();
      resetn = 1'b1;
      tick();
      pulse(mk(8'h01, 32'h7, 16'h8, 16'd99, 2'd1, 8'h08));
      chk("t6_new_bytes", AW'(bus.req_bytes), AW'(99));
      chk("t6_new_acc", AW'(accept_cnt), AW'(1));
      for (int i = 0; i < 3 + 260; i++) pulse(mk(8'h01, 32'h7, 16'h8, 16'(i), 2'd1, 8'h08));
      chk("t6_sat", AW'(drop_cnt), AW'(8'hFF));
      pulse(mk(8'h01, 32'h7, 16'h8, 16'd1, 2'd1, 8'h08));
      chk("t6_sat_hold", AW'(drop_cnt), AW'(8'hFF));
      clr();
      chk("t6_clr", AW'(drop_cnt), '0);
      chk("t6_clr_keeps", AW'(bus.req_bytes), AW'(99));
      bus.req_ready = 1'b1;
      tick(5);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         bus.pkt_valid = ($urandom_range(0, 2) != 0);
         bus.pkt_attributes = AW'({$urandom, $urandom, $urandom, $urandom, $urandom});
         bus.req_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         if (i % 250 == 0) cfg_prtcl_en = 4'($urandom);
         cfg_clr_cnt = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 899) == 0) begin
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
         end
         tick();
      end
      bus.pkt_valid = 1'b0;
      cfg_clr_cnt = 1'b0;
      tick(3);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/attr_lookup_requester.md
Name: attr_lookup_requester

Overview:
- Consumer of the packet-analyzer result interface (`pkt_valid` / `pkt_attributes`) driven by the protocol-combination analyzers in the monitoring output port lookup.
- Filters each result by protocol ID and buffers it in a small FIFO.
- Unpacks the attribute word into fields and presents a lookup request to the downstream tuple lookup stage over a valid/ready handshake.
- Counts accepted, filtered and dropped results.

Parameters:
- `ATTRIBUTE_DATA_WIDTH`, 135, width of the packed attribute word.
- `TUPLE_WIDTH`, 104, width of the proto/IP/port tuple, taken from attribute bits [103:0].
- `BYTES_COUNT_WIDTH`, 16, width of the byte-count field.
- `PKT_FLAGS_WIDTH`, 5, width of the packet-flags field.
- `PRTCL_ID_WIDTH`, 2, width of the protocol/priority ID field.
- `NUM_INPUT_QUEUES`, 8, width of the one-hot input-interface field.
- `FIFO_DEPTH`, 4, request buffer entries; must be a power of two and at least 2.
- `CNT_WIDTH`, 32, width of the statistics counters.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `pkt_valid`  in  1  one-cycle pulse: `pkt_attributes` is valid this cycle.
- `pkt_attributes`  in  `ATTRIBUTE_DATA_WIDTH`  packed result. Field layout, LSB first:
  - proto 8
  - ip_src 32
  - ip_dst 32
  - port_src 16
  - port_dst 16
  - bytes `BYTES_COUNT_WIDTH`
  - flags `PKT_FLAGS_WIDTH`
  - prtcl_id `PRTCL_ID_WIDTH`
  - input_if `NUM_INPUT_QUEUES`
- `cfg_prtcl_en`  in  2^`PRTCL_ID_WIDTH`  per-prtcl_id enable; bit k=1 forwards results with prtcl_id==k.
- `cfg_clr_cnt`  in  1  synchronous clear of all counters.
- `req_valid`  out  1  a request is at the FIFO head.
- `req_ready`  in  1  downstream accepts the head this cycle.
- `req_tuple`  out  `TUPLE_WIDTH`  attribute bits [`TUPLE_WIDTH`-1:0].
- `req_bytes`  out  `BYTES_COUNT_WIDTH`  byte count.
- `req_flags`  out  `PKT_FLAGS_WIDTH`  packet flags.
- `req_prtcl_id`  out  `PRTCL_ID_WIDTH`  protocol/priority ID.
- `req_input_if`  out  `NUM_INPUT_QUEUES`  source interface (one-hot).
- `accept_cnt`  out  `CNT_WIDTH`  results written into the FIFO.
- `filter_cnt`  out  `CNT_WIDTH`  results discarded by `cfg_prtcl_en`.
- `drop_cnt`  out  `CNT_WIDTH`  enabled results lost because the FIFO was full.

Behaviour:
- Reset (`resetn`=0, asynchronous):
  - FIFO emptied: read/write pointers and occupancy cleared, so `req_valid`=0.
  - All counters cleared to 0.
  - `req_*` data outputs are don't-care while `req_valid`=0; the bench must not check them.
- Reset mid-operation discards all buffered requests. After `resetn` rises, the first `pkt_valid` pulse is treated as a fresh result.
- Field extraction is purely positional; there is no sign or width conversion.
- Each cycle with `pkt_valid`=1 falls into exactly one class:
  - **filtered**: `cfg_prtcl_en`[prtcl_id]==0. Not written; `filter_cnt`+1.
  - **accepted**: enabled, and (occupancy < `FIFO_DEPTH` OR (`req_valid` AND `req_ready`) this cycle). Written; `accept_cnt`+1.
  - **dropped**: enabled and neither accepted condition holds. Not written; `drop_cnt`+1.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When full, a same-cycle pop frees the slot, so the push is accepted (no drop).
  - When empty, the pushed entry is not bypassed; it appears at the head the next cycle.
- Latency: result accepted in cycle N gives `req_valid`=1 with its fields in cycle N+1 at the earliest. Entries are delivered in FIFO order.
- Handshake:
  - A transfer occurs when `req_valid` AND `req_ready`.
  - While `req_valid`=1 and `req_ready`=0, all `req_*` outputs stay stable.
  - `req_valid` never deasserts without a transfer except on reset.
  - `req_ready` may be high while `req_valid`=0; nothing happens.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap modulo `FIFO_DEPTH`. Occupancy is log2(`FIFO_DEPTH`)+1 bits, ranging 0..`FIFO_DEPTH`.
- Counters:
  - Saturate at all-ones and never wrap.
  - `cfg_clr_cnt`=1 forces all three counters to 0 that cycle, overriding any increment. FIFO contents are unaffected.
- `cfg_prtcl_en` is sampled in the same cycle as `pkt_valid`. A configuration change does not affect entries already buffered.
- Internal state: per-entry storage array, write pointer, read pointer, occupancy, and three counters. All are clocked on `clk` and asynchronously reset, except the data array, which has no reset.

Test Plan:
1. Single result, `cfg_prtcl_en`=4'b1111, `req_ready`=1. `pkt_valid` pulse with proto=8'h06, ip_src=32'h0A000001, port_dst=16'h0050, bytes=16'd64, prtcl_id=2'd1, input_if=8'h04.
   - Cycle N+1: `req_valid`=1 with `req_tuple`[7:0]=8'h06, `req_bytes`=64, `req_input_if`=8'h04.
   - Cycle N+2: `req_valid`=0.
   - `accept_cnt`=1.
2. `cfg_prtcl_en`=4'b0111, results with prtcl_id=3 and then prtcl_id=0.
   - Only the prtcl_id=0 result reaches `req_*`.
   - `filter_cnt`=1, `accept_cnt`=1.
3. `req_ready`=0, six consecutive enabled pulses (bytes 1..6).
   - Occupancy reaches 4; `drop_cnt`=2, `accept_cnt`=4.
   - Then `req_ready`=1: outputs bytes 1,2,3,4 in order, then `req_valid`=0.
4. FIFO full, `req_ready`=1 and `pkt_valid`=1 in the same cycle.
   - Push accepted, `drop_cnt` unchanged, occupancy stays 4.
   - Subsequent drain shows the new entry last.
5. Backpressure stability: `req_valid`=1 with `req_ready` toggled 0,0,1.
   - `req_*` held constant for the two stalled cycles; exactly one transfer.
6. Reset mid-operation: `resetn` pulsed low with 3 entries buffered and counters non-zero.
   - Immediately `req_valid`=0 and all counters 0.
   - After release, one new pulse appears at `req_*` one cycle later.
   - Separately, `drop_cnt` forced to all-ones saturates on a further drop; `cfg_clr_cnt` returns it to 0.
